state_event_logger: RTL and testbench

Downstream consumer of the state monitor's transient flag and buffered input snapshot. On each new transient (rising edge of `transient`), it captures the 8-bit input state and a millisecond-resolution timestamp into a small FIFO. It then streams each record out as a 4-byte frame over a valid/ready byte interface, for a UART or host-readout stage. FIFO overflow is counted and flagged, never silently hidden.

---
 rtl/state_log_pkg.sv | 35 +++
 rtl/event_fifo.sv | 51 +++++
 rtl/state_event_logger.sv | 150 +++++++++++++++
 tb/tb_state_event_logger.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/state_log_pkg.sv
// Shared types and constants for the transient event logger: record layout,
// frame constants and the readout state encoding.
package state_log_pkg;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam int         FRAME_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        STATE,
        TSH,
        TSL
    } log_state_t;

    typedef struct packed {
        logic [7:0]  state;
        logic [15:0] ts;
    } log_record_t;

    // Byte presented on the output while the readout FSM sits in st.
    function automatic logic [7:0] frame_byte(input log_state_t st, input log_record_t rec);
        logic [7:0] b;
        b = 8'h00;
        case (st)
            HDR:     b = SYNC_BYTE;
            STATE:   b = rec.state;
            TSH:     b = rec.ts[15:8];
            TSL:     b = rec.ts[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/event_fifo.sv
// Small synchronous FIFO with extra-bit pointers. A push while full is only
// accepted when a pop frees a slot in the same cycle; a pop while empty is ignored.
module event_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign level   = wr_ptr_reg - rd_ptr_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end

    // Combinational read so the head record reaches the frame register in the pop cycle.
    assign rd_data = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/state_event_logger.sv
// Captures {state_in, timestamp} on each rising edge of transient into a FIFO
// and streams every record out as a 4-byte frame: A5, state, ts_hi, ts_lo.
module state_event_logger
    import state_log_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int TS_W     = 16,
    parameter int PRESCALE = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     transient,
    input  logic [7:0]               state_in,
    input  logic                     clear_ovf,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic [7:0]               drop_count
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic              transient_d_reg;
    logic [PS_W-1:0]   prescale_reg;
    logic [TS_W-1:0]   ts_reg;
    logic              overflow_reg;
    logic [7:0]        drop_count_reg;

    logic              evt;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    log_record_t       wr_rec;
    log_record_t       rd_rec;

    log_state_t        state_reg,     state_next;
    log_record_t       frame_reg,     frame_next;
    logic [7:0]        out_data_reg,  out_data_next;
    logic              out_valid_reg, out_valid_next;
    logic              hs;

    assign evt    = transient && !transient_d_reg;
    assign wr_rec = '{state: state_in, ts: ts_reg};
    // A full FIFO still takes the event when the readout pops in the same cycle.
    assign drop   = evt && fifo_full && !fifo_pop;
    assign hs     = out_valid_reg && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            transient_d_reg <= 1'b0;
            prescale_reg    <= '0;
            ts_reg          <= '0;
        end else begin
            transient_d_reg <= transient;
            if (prescale_reg == PS_W'(PRESCALE - 1)) begin
                prescale_reg <= '0;
                ts_reg       <= ts_reg + TS_W'(1);
            end else begin
                prescale_reg <= prescale_reg + PS_W'(1);
            end
        end
    end

    event_fifo #(
        .WIDTH ($bits(log_record_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (evt),
        .pop     (fifo_pop),
        .wr_data (wr_rec),
        .rd_data (rd_rec),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // A drop takes priority over a concurrent clear, so it is never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_reg   <= 1'b0;
            drop_count_reg <= 8'h00;
        end else if (drop) begin
            overflow_reg <= 1'b1;
            if (clear_ovf)
                drop_count_reg <= 8'd1;
            else if (drop_count_reg != 8'hFF)
                drop_count_reg <= drop_count_reg + 8'd1;
        end else if (clear_ovf) begin
            overflow_reg   <= 1'b0;
            drop_count_reg <= 8'h00;
        end
    end

    always_comb begin
        state_next = state_reg;
        frame_next = frame_reg;
        fifo_pop   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    frame_next = rd_rec;
                    state_next = HDR;
                end
            end
            HDR:   if (hs) state_next = STATE;
            STATE: if (hs) state_next = TSH;
            TSH:   if (hs) state_next = TSL;
            TSL: begin
                if (hs) begin
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        frame_next = rd_rec;
                        state_next = HDR;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        out_valid_next = (state_next != IDLE);
        out_data_next  = frame_byte(state_next, frame_next);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            frame_reg     <= '0;
            out_data_reg  <= 8'h00;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            frame_reg     <= frame_next;
            out_data_reg  <= out_data_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign out_data   = out_data_reg;
    assign out_valid  = out_valid_reg;
    assign overflow   = overflow_reg;
    assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_state_event_logger.sv
// Directed bench for state_event_logger: expected frame bytes are queued when
// events are driven and compared as the DUT hands them over.
module tb_state_event_logger;

    localparam int DEPTH    = 4;
    localparam int PRESCALE = 10;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   transient = 1'b0;
    logic [7:0]             state_in = 8'h00;
    logic                   clear_ovf = 1'b0;
    logic                   out_ready = 1'b0;
    logic [7:0]             out_data;
    logic                   out_valid;
    logic [$clog2(DEPTH):0] fifo_level;
    logic                   overflow;
    logic [7:0]             drop_count;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         hs_count = 0;
    bit         sb_en = 1'b1;
    logic [7:0] exp_q[$];
    bit         stall_prev = 1'b0;
    logic [7:0] stall_data = 8'h00;

    state_event_logger #(
        .DEPTH    (DEPTH),
        .TS_W     (16),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .transient  (transient),
        .state_in   (state_in),
        .clear_ovf  (clear_ovf),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Handshakes complete at the next posedge; inputs are stable at the negedge.
    always @(negedge clk) begin
        logic [7:0] e;
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", {31'd0, out_valid}, 32'd1);
                chk("hold_data", {24'd0, out_data}, {24'd0, stall_data});
            end
            if (out_valid && out_ready) begin
                hs_count++;
                if (sb_en) begin
                    e = 8'hxx;
                    if (exp_q.size() > 0) e = exp_q.pop_front();
                    chk("frame_byte", {24'd0, out_data}, {24'd0, e});
                    $display("byte %02h accepted (expected %02h)", out_data, e);
                end
            end
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic reset_dut();
        reset     = 1'b1;
        transient = 1'b0;
        clear_ovf = 1'b0;
        repeat (2) step();
        exp_q.delete();
        reset = 1'b0;
        cyc   = 0;
    endtask

    // One event: transient high for one cycle, then low for one cycle.
    task automatic fire(input logic [7:0] s, input bit keep, input bit clr);
        logic [15:0] ts;
        ts        = 16'((cyc / PRESCALE) % 65536);
        state_in  = s;
        transient = 1'b1;
        clear_ovf = clr;
        if (keep) begin
            exp_q.push_back(8'hA5);
            exp_q.push_back(s);
            exp_q.push_back(ts[15:8]);
            exp_q.push_back(ts[7:0]);
        end
        $display("event state=%02h ts=%04h keep=%0d clr=%0d", s, ts, keep, clr);
        step();
        transient = 1'b0;
        clear_ovf = 1'b0;
        step();
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            step();
            n++;
        end
        chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_idle"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] bp [4];
        bp[0] = 2'd1; bp[1] = 2'd0; bp[2] = 2'd0; bp[3] = 2'd1;

        // Reset values, idle for 100 cycles, then an event stamped ts=10
        reset_dut();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", {24'd0, out_data}, 32'h00);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_drops", {24'd0, drop_count}, 32'd0);
        repeat (100) step();
        chk("idle_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_level", 32'(fifo_level), 32'd0);
        out_ready = 1'b1;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h81);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h0A);
        state_in  = 8'h81;
        transient = 1'b1;
        step();
        transient = 1'b0;
        step();
        drain("ts10");

        // Event at cycle 25: bytes A5,3C,00,02 on cycles 27..30
        reset_dut();
        out_ready = 1'b1;
        state_in  = 8'h3C;
        repeat (25) step();
        transient = 1'b1;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h02);
        step();
        chk("lat_level_n1", 32'(fifo_level), 32'd1);
        chk("lat_valid_n1", {31'd0, out_valid}, 32'd0);
        transient = 1'b0;
        step();
        chk("lat_valid_n2", {31'd0, out_valid}, 32'd1);
        chk("lat_data_n2", {24'd0, out_data}, 32'hA5);
        chk("lat_level_n2", 32'(fifo_level), 32'd0);
        repeat (4) step();
        chk("lat_valid_end", {31'd0, out_valid}, 32'd0);
        chk("lat_sb_empty", 32'(exp_q.size()), 32'd0);

        // Overflow: frame register plus 4 stored, the sixth event drops
        reset_dut();
        out_ready = 1'b0;
        fire(8'h01, 1'b1, 1'b0);
        fire(8'h02, 1'b1, 1'b0);
        fire(8'h03, 1'b1, 1'b0);
        fire(8'h04, 1'b1, 1'b0);
        fire(8'h05, 1'b1, 1'b0);
        chk("full_level", 32'(fifo_level), 32'd4);
        chk("full_no_ovf", {31'd0, overflow}, 32'd0);
        fire(8'h06, 1'b0, 1'b0);
        chk("drop_level", 32'(fifo_level), 32'd4);
        chk("drop_ovf", {31'd0, overflow}, 32'd1);
        chk("drop_count1", {24'd0, drop_count}, 32'd1);
        hs_count  = 0;
        out_ready = 1'b1;
        drain("ovf");
        chk("ovf_frames_bytes", 32'(hs_count), 32'd20);
        chk("ovf_level_end", 32'(fifo_level), 32'd0);

        // Backpressure 1,0,0,1 inside a frame
        reset_dut();
        out_ready = 1'b0;
        fire(8'h5A, 1'b1, 1'b0);
        chk("bp_valid", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            out_ready = bp[i][0];
            step();
        end
        out_ready = 1'b1;
        drain("bp");

        // Pulse train with full throughput, then saturation and clear
        reset_dut();
        out_ready = 1'b1;
        sb_en     = 1'b0;
        for (int i = 0; i < 20; i++) fire(8'(i), 1'b0, 1'b0);
        chk("train_ovf", {31'd0, overflow}, 32'd1);
        chk("train_dropped", {31'd0, drop_count != 8'd0}, 32'd1);
        out_ready = 1'b0;
        for (int i = 0; i < 300; i++) fire(8'(i), 1'b0, 1'b0);
        chk("sat_drops", {24'd0, drop_count}, 32'd255);
        chk("sat_ovf", {31'd0, overflow}, 32'd1);
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        chk("clr_ovf", {31'd0, overflow}, 32'd0);
        chk("clr_drops", {24'd0, drop_count}, 32'd0);
        fire(8'h11, 1'b0, 1'b1);
        chk("clr_drop_ovf", {31'd0, overflow}, 32'd1);
        chk("clr_drop_count", {24'd0, drop_count}, 32'd1);

        // Reset during the TSH byte discards the frame
        reset_dut();
        sb_en     = 1'b1;
        out_ready = 1'b0;
        fire(8'hC3, 1'b1, 1'b0);
        out_ready = 1'b1;
        repeat (2) step();
        out_ready = 1'b0;
        chk("tsh_valid", {31'd0, out_valid}, 32'd1);
        chk("tsh_data", {24'd0, out_data}, 32'h00);
        reset = 1'b1;
        step();
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_level", 32'(fifo_level), 32'd0);
        exp_q.delete();
        step();
        reset     = 1'b0;
        cyc       = 0;
        out_ready = 1'b0;
        fire(8'h7E, 1'b1, 1'b0);
        chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
        chk("post_rst_hdr", {24'd0, out_data}, 32'hA5);
        out_ready = 1'b1;
        drain("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
